// File: rtl/starfield_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : starfield_ctrl
//  Description : Schedules shift-enable and reseed pulses for LAYERS parallax
//                starfield LFSRs. Each layer reseeds every AREA+inc area
//                pixels, so its star pattern slides by inc pixels per frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module starfield_ctrl #(
    parameter int CORDW  = 16,
    parameter int LAYERS = 3,
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int INCW   = 8,
    parameter int CNTW   = 20
) (
    input  logic                      clk_pix,
    input  logic                      rst_pix,
    input  logic                      frame,
    input  logic                      de,
    input  logic signed [CORDW-1:0]   sx,
    input  logic signed [CORDW-1:0]   sy,
    input  logic                      run,
    input  logic [LAYERS*INCW-1:0]    inc,
    output logic [LAYERS-1:0]         lfsr_en,
    output logic [LAYERS-1:0]         lfsr_rst,
    output logic                      ready,
    output logic [15:0]               frame_cnt
);

    localparam logic signed [CORDW-1:0] c_H_RES = CORDW'(H_RES);
    localparam logic signed [CORDW-1:0] c_V_RES = CORDW'(V_RES);
    localparam logic [CNTW-1:0]         c_AREA  = CNTW'(H_RES * V_RES);

    typedef enum logic [0:0] {
        ST_WAIT   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t      r_state;
    logic        r_ready;
    logic [15:0] r_frame_cnt;
    logic        w_area;

    // Visible starfield pixel: enabled and inside the non-negative area box
    assign w_area = de
                 && !sx[CORDW-1] && (sx < c_H_RES)
                 && !sy[CORDW-1] && (sy < c_V_RES);

    // Top-level state: parked until the first frame pulse, then running.
    // The pulse that starts the first frame counts as frame 1.
    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            r_state     <= ST_WAIT;
            r_ready     <= 1'b0;
            r_frame_cnt <= 16'd0;
        end else begin
            case (r_state)
                ST_WAIT: begin
                    r_ready <= 1'b0;
                    if (frame) begin
                        r_state     <= ST_ACTIVE;
                        r_ready     <= 1'b1;
                        r_frame_cnt <= r_frame_cnt + 16'd1;
                    end
                end
                ST_ACTIVE: begin
                    r_ready <= 1'b1;
                    if (frame) begin
                        r_frame_cnt <= r_frame_cnt + 16'd1;
                    end
                end
                default: begin
                    r_state <= ST_WAIT;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign ready     = r_ready;
    assign frame_cnt = r_frame_cnt;

    generate
        for (genvar l = 0; l < LAYERS; l++) begin : g_layer
            logic [CNTW-1:0] r_cnt;
            logic [INCW-1:0] r_inc_q;
            logic            r_en;
            logic            r_rst;
            logic [CNTW-1:0] w_inc_ext;
            logic [CNTW-1:0] w_limit;

            // Signed increment widened to counter width; limit is the last
            // count before a reseed (period = AREA + inc)
            assign w_inc_ext = {{(CNTW-INCW){r_inc_q[INCW-1]}}, r_inc_q};
            assign w_limit   = c_AREA + w_inc_ext - CNTW'(1);

            // Per-layer pixel counter with reseed pulse; increment latched at frame start
            always_ff @(posedge clk_pix) begin
                if (rst_pix) begin
                    r_cnt   <= '0;
                    r_inc_q <= '0;
                    r_en    <= 1'b0;
                    r_rst   <= 1'b1;
                end else begin
                    if (frame) begin
                        r_inc_q <= run ? inc[l*INCW +: INCW] : '0;
                    end
                    if (r_state == ST_ACTIVE) begin
                        r_en <= w_area;
                        if (w_area) begin
                            if (r_cnt == w_limit) begin
                                r_cnt <= '0;
                                r_rst <= 1'b1;
                            end else begin
                                r_cnt <= r_cnt + CNTW'(1);
                                r_rst <= 1'b0;
                            end
                        end else begin
                            r_rst <= 1'b0;
                        end
                    end else begin
                        r_en  <= 1'b0;
                        r_rst <= 1'b1;
                    end
                end
            end

            assign lfsr_en[l]  = r_en;
            assign lfsr_rst[l] = r_rst;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_starfield_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_starfield_ctrl
//  Description : Directed self-checking bench for starfield_ctrl on a tiny
//                8x4 starfield (AREA = 32) with three layers.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_starfield_ctrl;

    localparam int CORDW  = 16;
    localparam int LAYERS = 3;
    localparam int H_RES  = 8;
    localparam int V_RES  = 4;
    localparam int INCW   = 8;
    localparam int CNTW   = 20;

    logic                     clk_pix = 1'b0;
    logic                     rst_pix;
    logic                     frame;
    logic                     de;
    logic signed [CORDW-1:0]  sx;
    logic signed [CORDW-1:0]  sy;
    logic                     run;
    logic [LAYERS*INCW-1:0]   inc;
    logic [LAYERS-1:0]        lfsr_en;
    logic [LAYERS-1:0]        lfsr_rst;
    logic                     ready;
    logic [15:0]              frame_cnt;

    starfield_ctrl #(
        .CORDW (CORDW),
        .LAYERS(LAYERS),
        .H_RES (H_RES),
        .V_RES (V_RES),
        .INCW  (INCW),
        .CNTW  (CNTW)
    ) u_dut (
        .clk_pix  (clk_pix),
        .rst_pix  (rst_pix),
        .frame    (frame),
        .de       (de),
        .sx       (sx),
        .sy       (sy),
        .run      (run),
        .inc      (inc),
        .lfsr_en  (lfsr_en),
        .lfsr_rst (lfsr_rst),
        .ready    (ready),
        .frame_cnt(frame_cnt)
    );

    always #5 clk_pix = ~clk_pix;

    int total = 0;
    int bad   = 0;

    // Per-frame observations, indexed by layer
    int first_px [LAYERS];
    int n_pulse  [LAYERS];
    int n_en     [LAYERS];
    int px;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    // Drive one pixel, clock it, then observe the registered response
    task automatic step(input logic f, input logic d, input int x, input int y);
        logic is_area;
        frame = f;
        de    = d;
        sx    = CORDW'(x);
        sy    = CORDW'(y);
        @(posedge clk_pix);
        #1;
        is_area = d && (x >= 0) && (x < H_RES) && (y >= 0) && (y < V_RES);
        for (int l = 0; l < LAYERS; l++) begin
            if (lfsr_en[l] === 1'b1) n_en[l]++;
            if (is_area && lfsr_rst[l] === 1'b1) begin
                if (first_px[l] < 0) first_px[l] = px;
                n_pulse[l]++;
            end
        end
        if (is_area) px++;
    endtask

    task automatic clear_rec();
        for (int l = 0; l < LAYERS; l++) begin
            first_px[l] = -1;
            n_pulse[l]  = 0;
            n_en[l]     = 0;
        end
        px = 0;
    endtask

    task automatic do_reset();
        rst_pix = 1'b1;
        step(1'b0, 1'b0, -2, -1);
        step(1'b0, 1'b0, -2, -1);
        rst_pix = 1'b0;
    endtask

    // One frame: pulse cycle in blanking, then 4 lines of 8 visible + 2 blank
    task automatic run_frame(input int drop_px);
        clear_rec();
        step(1'b1, 1'b0, -2, -1);
        for (int y = 0; y < V_RES; y++) begin
            for (int x = 0; x < H_RES + 2; x++) begin
                if (x < H_RES && (y * H_RES + x) == drop_px) run = 1'b0;
                step(1'b0, x < H_RES, x, y);
            end
        end
    endtask

    task automatic check_frame(input string tag, input int fc, input int p0, input int p1, input int p2);
        int exp_px [LAYERS];
        exp_px[0] = p0;
        exp_px[1] = p1;
        exp_px[2] = p2;
        check({tag, "_fcnt"}, 32'(frame_cnt), fc);
        check({tag, "_ready"}, 32'(ready), 1);
        for (int l = 0; l < LAYERS; l++) begin
            check($sformatf("%s_l%0d_px", tag, l), first_px[l], exp_px[l]);
            check($sformatf("%s_l%0d_npulse", tag, l), n_pulse[l], (exp_px[l] >= 0) ? 1 : 0);
            check($sformatf("%s_l%0d_nen", tag, l), n_en[l], 32);
        end
    endtask

    initial begin
        int idle_bad;
        rst_pix = 1'b0;
        frame   = 1'b0;
        de      = 1'b0;
        sx      = '0;
        sy      = '0;
        run     = 1'b1;
        inc     = '0;
        clear_rec();

        // Reset state
        do_reset();
        check("rst_lfsr_rst", 32'(lfsr_rst), 7);
        check("rst_lfsr_en", 32'(lfsr_en), 0);
        check("rst_ready", 32'(ready), 0);
        check("rst_fcnt", 32'(frame_cnt), 0);

        // No frame pulse for 100 cycles: stays parked even over area pixels
        idle_bad = 0;
        for (int i = 0; i < 100; i++) begin
            step(1'b0, 1'b1, i % H_RES, (i / H_RES) % V_RES);
            if (lfsr_rst !== 3'b111 || lfsr_en !== 3'b000 || ready !== 1'b0) idle_bad++;
        end
        check("idle_bad_cycles", idle_bad, 0);
        check("idle_lfsr_rst", 32'(lfsr_rst), 7);
        check("idle_ready", 32'(ready), 0);

        // Zero increment: reseed on area pixel 31 every frame
        inc = '0;
        run = 1'b1;
        run_frame(-1);
        check_frame("zero_f1", 1, 31, 31, 31);
        run_frame(-1);
        check_frame("zero_f2", 2, 31, 31, 31);
        run_frame(-1);
        check_frame("zero_f3", 3, 31, 31, 31);

        // Reset asserted mid-area for one cycle
        clear_rec();
        step(1'b1, 1'b0, -2, -1);
        for (int x = 0; x < 5; x++) step(1'b0, 1'b1, x, 0);
        rst_pix = 1'b1;
        step(1'b0, 1'b1, 5, 0);
        rst_pix = 1'b0;
        check("midrst_lfsr_rst", 32'(lfsr_rst), 7);
        check("midrst_lfsr_en", 32'(lfsr_en), 0);
        check("midrst_ready", 32'(ready), 0);
        check("midrst_fcnt", 32'(frame_cnt), 0);
        for (int x = 6; x < H_RES; x++) step(1'b0, 1'b1, x, 0);
        for (int y = 1; y < V_RES; y++)
            for (int x = 0; x < H_RES; x++) step(1'b0, 1'b1, x, y);
        check("midrst_parked_rst", 32'(lfsr_rst), 7);
        check("midrst_parked_ready", 32'(ready), 0);
        run_frame(-1);
        check_frame("midrst_f1", 1, 31, 31, 31);

        // Per-layer increments: layer0 = -1, layer1 = +2, layer2 = 0
        do_reset();
        inc = {8'h00, 8'h02, 8'hFF};
        run = 1'b1;
        run_frame(-1);
        check_frame("inc_f1", 1, 30, -1, 31);
        run_frame(-1);
        check_frame("inc_f2", 2, 29, 1, 31);
        run_frame(-1);
        check_frame("inc_f3", 3, 28, 3, 31);

        // All layers at -1; run dropped mid frame 2 -> period 31 then 32
        do_reset();
        inc = {8'hFF, 8'hFF, 8'hFF};
        run = 1'b1;
        run_frame(-1);
        check_frame("drop_f1", 1, 30, 30, 30);
        run_frame(10);
        check_frame("drop_f2", 2, 29, 29, 29);
        run_frame(-1);
        check_frame("drop_f3", 3, 29, 29, 29);
        run_frame(-1);
        check_frame("drop_f4", 4, 29, 29, 29);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety bound so the bench always terminates
    initial begin
        #200000;
        bad++;
        $display("FAIL timeout: got running expected finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
